// File: rtl/serve_sequencer.sv
// serve_sequencer: serve/launch/settle/play/cool-down game-flow FSM with server rotation and free-running seed counter.
module serve_sequencer #(
  parameter int SETTLE_CYCLES = 24,
  parameter int SERVE_ROTATE  = 2,
  parameter int COOL_CYCLES   = 48
) (
  input  logic       clk_1,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       serve_req_a,
  input  logic       serve_req_b,
  input  logic       ball_out,
  input  logic       game_over,
  output logic       Initial_ball,
  output logic [8:0] cnt,
  output logic       ball_valid,
  output logic       server,
  output logic       busy,
  output logic [2:0] state
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_PLAY   = 3'd3;
  localparam logic [2:0] S_COOL   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] COOL_LD   = 8'(COOL_CYCLES - 1);
  localparam logic [3:0] ROT_LAST  = 4'(SERVE_ROTATE - 1);

  logic [2:0] r_state;
  logic [7:0] r_timer;
  logic [3:0] r_rot;
  logic       r_server;
  logic [8:0] r_cnt;
  logic       r_init;
  logic       r_valid;
  logic       r_busy;
  logic [2:0] w_next;
  logic [7:0] w_timer;
  logic [3:0] w_rot;
  logic       w_server;
  logic       w_accept;
  logic       w_point;
  logic       w_init;
  logic       w_valid;
  logic       w_busy;

  assign w_accept = r_server ? serve_req_b : serve_req_a;
  assign w_point  = (r_state == S_PLAY) && ball_out;

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // The settle timer is loaded on entry to LAUNCH so the launch cycle itself counts toward the settle delay.
  always_comb begin
    w_next  = S_IDLE;
    w_timer = r_timer;
    if (new_game) begin
      w_next  = S_IDLE;
      w_timer = '0;
    end else if (game_over && r_state != S_HALT) begin
      w_next = S_HALT;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next  = w_accept ? S_LAUNCH : S_IDLE;
          w_timer = w_accept ? SETTLE_LD : r_timer;
        end
        S_LAUNCH: begin
          w_next  = S_SETTLE;
          w_timer = r_timer - 8'd1;
        end
        S_SETTLE: begin
          w_next  = (r_timer == 8'd0) ? S_PLAY : S_SETTLE;
          w_timer = (r_timer == 8'd0) ? r_timer : r_timer - 8'd1;
        end
        S_PLAY: begin
          w_next  = ball_out ? S_COOL : S_PLAY;
          w_timer = ball_out ? COOL_LD : r_timer;
        end
        S_COOL: begin
          w_next  = (r_timer == 8'd0) ? S_IDLE : S_COOL;
          w_timer = (r_timer == 8'd0) ? r_timer : r_timer - 8'd1;
        end
        S_HALT:  w_next = S_HALT;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Rotation tracks every finished point, even one that coincides with game_over.
  always_comb begin
    w_rot    = r_rot;
    w_server = r_server;
    if (new_game) begin
      w_rot    = '0;
      w_server = 1'b0;
    end else if (w_point) begin
      w_rot    = (r_rot == ROT_LAST) ? 4'd0 : r_rot + 4'd1;
      w_server = (r_rot == ROT_LAST) ? ~r_server : r_server;
    end
  end

  always_comb begin
    w_init  = (w_next == S_LAUNCH);
    w_valid = (w_next == S_PLAY);
    w_busy  = (w_next == S_LAUNCH) || (w_next == S_SETTLE) || (w_next == S_PLAY) || (w_next == S_COOL);
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      r_timer  <= '0;
      r_rot    <= '0;
      r_server <= 1'b0;
      r_cnt    <= '0;
      r_init   <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_timer  <= w_timer;
      r_rot    <= w_rot;
      r_server <= w_server;
      r_cnt    <= r_cnt + 9'd1;
      r_init   <= w_init;
      r_valid  <= w_valid;
      r_busy   <= w_busy;
    end
  end

  assign Initial_ball = r_init;
  assign cnt          = r_cnt;
  assign ball_valid   = r_valid;
  assign server       = r_server;
  assign busy         = r_busy;
  assign state        = r_state;
endmodule

// File: tb/tb_serve_sequencer.sv
// tb_serve_sequencer: directed checks of serve acceptance, settle/cool timing, rotation, halt and reset behaviour.
module tb_serve_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic       serve_req_a = 1'b0;
  logic       serve_req_b = 1'b0;
  logic       ball_out = 1'b0;
  logic       game_over = 1'b0;
  logic       Initial_ball;
  logic [8:0] cnt;
  logic       ball_valid;
  logic       server;
  logic       busy;
  logic [2:0] state;
  int         total = 0;
  int         bad = 0;
  int         cyc;
  int         n_init;

  serve_sequencer dut (
    .clk_1(clk), .rst_n(rst_n), .new_game(new_game), .serve_req_a(serve_req_a),
    .serve_req_b(serve_req_b), .ball_out(ball_out), .game_over(game_over),
    .Initial_ball(Initial_ball), .cnt(cnt), .ball_valid(ball_valid),
    .server(server), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset release; cnt must track this mod 512.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_init"}, 32'(Initial_ball), 0);
    chk({tag, "_valid"}, 32'(ball_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_server"}, 32'(server), 0);
    chk({tag, "_cnt"}, 32'(cnt), 0);
  endtask

  task automatic play_point(input logic b, input int exp_wait, input logic exp_srv, input string tag);
    int n;
    n = 0;
    serve_req_a = !b;
    serve_req_b = b;
    while (!Initial_ball && n < 80) begin tick(1); n++; end
    chk({tag, "_launch_wait"}, 32'(n), 32'(exp_wait));
    chk({tag, "_launch_state"}, 32'(state), 1);
    serve_req_a = 1'b0;
    serve_req_b = 1'b0;
    n = 0;
    while (!ball_valid && n < 40) begin tick(1); n++; end
    chk({tag, "_settle_len"}, 32'(n), 24);
    chk({tag, "_play_state"}, 32'(state), 3);
    ball_out = 1'b1;
    tick(1);
    ball_out = 1'b0;
    chk({tag, "_cool_state"}, 32'(state), 4);
    chk({tag, "_cool_valid"}, 32'(ball_valid), 0);
    chk({tag, "_server"}, 32'(server), 32'(exp_srv));
  endtask

  initial begin
    tick(2);
    chk_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick(1);
      chk("cnt_run", 32'(cnt), 32'(cyc % 512));
    end
    chk("cnt_wrap_end", 32'(cnt), 88);
    chk("idle_hold", 32'(state), 0);
    serve_req_b = 1'b1;
    n_init = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      n_init += int'(Initial_ball);
    end
    chk("nonserver_launches", 32'(n_init), 0);
    chk("nonserver_state", 32'(state), 0);
    serve_req_a = 1'b1;
    tick(1);
    chk("both_launch", 32'(Initial_ball), 1);
    chk("both_launch_state", 32'(state), 1);
    chk("both_launch_busy", 32'(busy), 1);
    chk("launch_cnt", 32'(cnt), 32'(cyc % 512));
    serve_req_a = 1'b0;
    serve_req_b = 1'b0;
    tick(1);
    chk("launch_one_cycle", 32'(Initial_ball), 0);
    chk("settle_state", 32'(state), 2);
    tick(22);
    chk("settle_valid_early", 32'(ball_valid), 0);
    tick(1);
    chk("settle_valid_24", 32'(ball_valid), 1);
    chk("p1_play_state", 32'(state), 3);
    ball_out = 1'b1;
    tick(1);
    ball_out = 1'b0;
    chk("p1_cool_state", 32'(state), 4);
    chk("p1_cool_valid", 32'(ball_valid), 0);
    chk("p1_server", 32'(server), 0);
    play_point(1'b0, 49, 1'b1, "p2");
    play_point(1'b1, 49, 1'b1, "p3");
    play_point(1'b1, 49, 1'b0, "p4");
    play_point(1'b0, 49, 1'b0, "p5");
    ball_out = 1'b1;
    tick(1);
    ball_out = 1'b0;
    chk("stray_out_server", 32'(server), 0);
    chk("stray_out_state", 32'(state), 4);
    play_point(1'b0, 48, 1'b1, "p6");
    game_over = 1'b1;
    tick(1);
    chk("go_cool_state", 32'(state), 5);
    chk("go_cool_valid", 32'(ball_valid), 0);
    chk("go_cool_busy", 32'(busy), 0);
    chk("go_cool_server", 32'(server), 1);
    tick(10);
    chk("halt_hold", 32'(state), 5);
    game_over = 1'b0;
    serve_req_b = 1'b1;
    tick(3);
    chk("halt_no_exit", 32'(state), 5);
    chk("halt_no_launch", 32'(Initial_ball), 0);
    new_game = 1'b1;
    tick(1);
    chk("newgame_state", 32'(state), 0);
    chk("newgame_server", 32'(server), 0);
    new_game = 1'b0;
    serve_req_b = 1'b0;
    new_game = 1'b1;
    game_over = 1'b1;
    tick(1);
    chk("ng_go_first", 32'(state), 0);
    new_game = 1'b0;
    tick(1);
    chk("ng_go_second", 32'(state), 5);
    game_over = 1'b0;
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    chk("ng_exit", 32'(state), 0);
    serve_req_a = 1'b1;
    tick(1);
    serve_req_a = 1'b0;
    chk("rst_launch_pre", 32'(Initial_ball), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_launch");
    @(negedge clk) rst_n = 1'b1;
    serve_req_a = 1'b1;
    tick(1);
    serve_req_a = 1'b0;
    tick(5);
    chk("rst_settle_pre", 32'(state), 2);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_settle");
    @(negedge clk) rst_n = 1'b1;
    serve_req_a = 1'b1;
    tick(1);
    serve_req_a = 1'b0;
    tick(5);
    chk("go_settle_pre", 32'(state), 2);
    game_over = 1'b1;
    tick(1);
    chk("go_settle_state", 32'(state), 5);
    chk("go_settle_valid", 32'(ball_valid), 0);
    chk("go_settle_busy", 32'(busy), 0);
    tick(30);
    chk("go_settle_hold_valid", 32'(ball_valid), 0);
    chk("go_settle_hold_state", 32'(state), 5);
    game_over = 1'b0;
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    chk("go_settle_exit", 32'(state), 0);
    chk("go_settle_server", 32'(server), 0);
    tick(1);
    chk("go_settle_idle", 32'(state), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serve_sequencer.md
Name: serve_sequencer

Overview:
- Game-flow controller that sequences the ball-randomisation/velocity-decomposition datapath.
- Accepts a serve request only from the designated server and fires a one-cycle Initial_ball launch pulse.
- Waits out the velocity-decomposition latency, then flags the ball as valid for the motion/collision logic.
- After each point it enforces a cool-down, rotates the server every SERVE_ROTATE points, and supplies the free-running 9-bit cnt seed to the randomiser.

Parameters:
SETTLE_CYCLES, 24, clk_1 cycles from Initial_ball to ball_valid; must be ≥ 21, the velocity-decomposition latency.
SERVE_ROTATE, 2, points per server before the serve passes to the other player; legal range 1..15.
COOL_CYCLES, 48, clk_1 cycles after ball_out before a new serve is accepted; must be ≥ 1.

Ports:
clk_1  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
new_game  input  1  synchronous restart pulse; ignored while rst_n is low.
serve_req_a  input  1  player A serve button, already debounced and synchronised, level.
serve_req_b  input  1  player B serve button, same conditioning as serve_req_a.
ball_out  input  1  one-cycle pulse: ball left play and the point is over.
game_over  input  1  level from the score keeper; freezes serving.
Initial_ball  output  1  one-cycle launch pulse to the randomiser.
cnt  output  9  free-running random seed to the randomiser.
ball_valid  output  1  ball velocity and location are settled and in play.
server  output  1  current server: 0 = A, 1 = B.
busy  output  1  high in LAUNCH, SETTLE, PLAY and COOL.
state  output  3  FSM state code, for debug and LED display.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, Initial_ball=0, ball_valid=0, server=0, busy=0, cnt=0, timer=0, rot_cnt=0.
- All outputs are registered.
- cnt: increments by 1 every clk_1 cycle in every state and wraps 511→0. It is not cleared by new_game.
- FSM state codes: IDLE=0, LAUNCH=1, SETTLE=2, PLAY=3, COOL=4, HALT=5. Codes 6 and 7 are illegal and return to IDLE on the next cycle.
- IDLE:
  - Stay while no accepted request.
  - Accepted request is (server==0 && serve_req_a) || (server==1 && serve_req_b). A request from the non-server is ignored, including when both players press together.
  - On an accepted request → LAUNCH.
- LAUNCH (exactly 1 cycle):
  - Initial_ball=1 only in this state.
  - The randomiser samples cnt in this cycle.
  - Timer loads SETTLE_CYCLES-1; next state → SETTLE.
- SETTLE:
  - Timer decrements each cycle; on timer==0 → PLAY.
  - ball_valid first goes high in the cycle that is SETTLE_CYCLES cycles after the Initial_ball cycle.
- PLAY:
  - ball_valid=1.
  - On ball_out: timer loads COOL_CYCLES-1, state → COOL, ball_valid falls next cycle.
  - Server rotation on the same ball_out: if rot_cnt==SERVE_ROTATE-1, then rot_cnt←0 and server toggles. Otherwise rot_cnt increments.
- COOL: timer decrements each cycle; on timer==0 → IDLE. Serve requests are ignored.
- ball_out outside PLAY is ignored: no rotation and no state change.
- A serve request held through COOL is accepted on the first IDLE cycle.
- game_over: high in any state except HALT → HALT next cycle. HALT drives ball_valid=0, busy=0, Initial_ball=0, and the timer freezes.
- HALT exits only on new_game → IDLE.
- new_game, in any state: next cycle state=IDLE, server=0, rot_cnt=0, timer=0, ball_valid=0.
- Priority, highest first: rst_n, new_game, game_over, normal transitions.
  - new_game together with game_over high → HALT, because game_over is re-evaluated on the following cycle.
  - ball_out together with game_over in PLAY → HALT, but rotation still applies.
- Reset mid-operation aborts any launch; no partial Initial_ball pulse is produced.
- Timer width is 8 bits, sized for both SETTLE_CYCLES and COOL_CYCLES ≤ 256.

Test Plan:
- Release reset; hold serve_req_a=1 at cycle 10 → Initial_ball high for exactly 1 cycle (cycle 11). ball_valid rises at cycle 35 (24 cycles later). state goes 0→1→2→3.
- server=0, serve_req_b=1 only → no Initial_ball for 100 cycles. Then serve_req_a and serve_req_b both =1 → exactly one launch.
- In PLAY pulse ball_out twice, serving from A each time with SERVE_ROTATE=2 → server=1 after the second ball_out. A fourth point returns server=0.
- ball_out at cycle T with serve_req_a held → ball_valid=0 at T+1. Next Initial_ball at T+COOL_CYCLES+2, i.e. COOL exits to IDLE at T+49 and the serve is accepted there.
- Free-run cnt for 600 cycles → values 0..511 then 0..87, contiguous with no skips. The Initial_ball cycle's cnt equals the cycle index mod 512.
- Reset and override cases, each run from a fresh reset:
  - game_over during SETTLE → HALT, no ball_valid. new_game → IDLE with server=0.
  - rst_n low mid-SETTLE → all outputs 0 immediately, before the next clock edge.
